// File: rtl/urv_csr_dbg_arb.sv
// rtl/urv_csr_dbg_arb.sv - arbitrates the CSR datapath between pipeline decode and debug host.
// Optional forced-hold on starvation: define URV_CSR_DBG_ARB_STARVE_EN.
module urv_csr_dbg_arb #(
  parameter int g_starve_limit = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p_csr_req_i,
  input  logic [2:0]  p_fun_i,
  input  logic [11:0] p_csr_sel_i,
  input  logic [31:0] p_rs1_i,
  input  logic [4:0]  p_imm_i,
  input  logic        p_kill_i,
  input  logic        x_stall_i,
  output logic        p_hold_o,
  output logic        csr_is_csr_o,
  output logic [2:0]  csr_fun_o,
  output logic [11:0] csr_sel_o,
  output logic [31:0] csr_rs1_o,
  output logic [4:0]  csr_imm_o,
  output logic        csr_kill_o,
  input  logic [31:0] csr_rd_i,
  input  logic        dbg_req_i,
  input  logic [1:0]  dbg_op_i,
  input  logic [11:0] dbg_sel_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_RESP,
    S_DRAIN
  } state_t;

  if (g_starve_limit < 1 || g_starve_limit > 255) begin : g_bad_limit
    $error("g_starve_limit must be in 1..255");
  end

  state_t      state_q;
  logic [1:0]  op_q;
  logic [11:0] sel_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        issue;

`ifdef URV_CSR_DBG_ARB_STARVE_EN
  localparam logic [7:0] LimM1 = 8'(g_starve_limit - 1);
  logic [7:0] cnt_q;
  logic       starve;
  assign starve = (cnt_q >= LimM1);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      sel_q   <= 12'h000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
`ifdef URV_CSR_DBG_ARB_STARVE_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dbg_req_i) begin
            op_q    <= dbg_op_i;
            sel_q   <= dbg_sel_i;
            wdata_q <= dbg_wdata_i;
`ifdef URV_CSR_DBG_ARB_STARVE_EN
            cnt_q   <= 8'd0;
`endif
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!p_csr_req_i) begin
            state_q <= S_ISSUE;
          end else begin
`ifdef URV_CSR_DBG_ARB_STARVE_EN
            if (starve) state_q <= S_ISSUE;
            else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        S_ISSUE: begin
          // The op only commits on an unstalled edge, so the old value is captured then.
          if (!x_stall_i) begin
            rdata_q <= csr_rd_i;
            ack_q   <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_DRAIN;
        S_DRAIN: if (!dbg_req_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign issue = (state_q == S_ISSUE);

  always_comb begin
    csr_is_csr_o = p_csr_req_i;
    csr_fun_o    = p_fun_i;
    csr_sel_o    = p_csr_sel_i;
    csr_rs1_o    = p_rs1_i;
    csr_imm_o    = p_imm_i;
    csr_kill_o   = p_kill_i;
    if (issue) begin
      csr_is_csr_o = 1'b1;
      csr_sel_o    = sel_q;
      csr_imm_o    = 5'd0;
      csr_kill_o   = 1'b0;
      csr_rs1_o    = (op_q == 2'b00) ? 32'h0 : wdata_q;
      case (op_q)
        2'b01:   csr_fun_o = 3'b001;
        2'b11:   csr_fun_o = 3'b011;
        default: csr_fun_o = 3'b010;
      endcase
    end
    // Dropping is_csr asynchronously keeps an interrupted op from committing.
    if (rst_i) csr_is_csr_o = 1'b0;
  end

  assign p_hold_o    = issue;
  assign dbg_ack_o   = ack_q;
  assign dbg_rdata_o = rdata_q;
  assign dbg_busy_o  = (state_q != S_IDLE);

endmodule
